// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the UART transmitter; issues one-cycle transmit pulses
// spaced at least FRAME_CYCLES apart. Pop latency: one cycle after acceptance.
module uart_tx_feeder #(
  parameter int N            = 8,
  parameter int DEPTH        = 8,
  parameter int AW           = 3,
  parameter int FRAME_CYCLES = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_wr_data,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  output logic [N-1:0]  o_tx_data,
  output logic          o_transmit,
  output logic [AW:0]   o_count,
  output logic          o_busy,
  output logic          o_wr_drop
);

  localparam int            GW     = $clog2(FRAME_CYCLES);
  localparam logic [GW-1:0] C_GAP  = GW'(FRAME_CYCLES - 1);
  localparam logic [AW:0]   C_FULL = (AW + 1)'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_gap;
  logic [GW-1:0] w_gap_nxt;
  logic          w_pop;

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [N-1:0]  r_tx_data;
  logic          r_transmit;
  logic          r_wr_drop;

  logic          w_wr_ready;
  logic          w_wr_acc;
  logic          w_wr_refuse;

  // Ready depends only on the pre-edge count, so a pop never frees a slot for
  // a write arriving at the same edge.
  assign w_wr_ready  = (r_count != C_FULL);
  assign w_wr_acc    = i_wr_valid && w_wr_ready;
  assign w_wr_refuse = i_wr_valid && !w_wr_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_gap_nxt   = C_GAP;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_gap != '0) begin
          w_gap_nxt = r_gap - 1'b1;
        end else if (r_count != '0) begin
          w_pop     = 1'b1;
          w_gap_nxt = C_GAP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_data  <= '0;
      r_transmit <= 1'b0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_transmit <= w_pop;
      r_wr_drop  <= w_wr_refuse;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_wr_ready = w_wr_ready;
  assign o_tx_data  = r_tx_data;
  assign o_transmit = r_transmit;
  assign o_count    = r_count;
  assign o_busy     = (r_state != S_IDLE) || (r_count != '0);
  assign o_wr_drop  = r_wr_drop;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a cycle table for the single-byte case
// plus sequences for reset, burst, overflow, full-pop and pointer wrap.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] tx_data;
  logic       transmit;
  logic [3:0] count;
  logic       busy;
  logic       wr_drop;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] tx_q[$];
  int         cyc_q[$];

  uart_tx_feeder dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr_data  (wr_data),
    .i_wr_valid (wr_valid),
    .o_wr_ready (wr_ready),
    .o_tx_data  (tx_data),
    .o_transmit (transmit),
    .o_count    (count),
    .o_busy     (busy),
    .o_wr_drop  (wr_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (transmit === 1'b1) begin
      tx_q.push_back(tx_data);
      cyc_q.push_back(cyc);
    end
  end

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       tx;
    logic [7:0] txd;
    logic [3:0] cnt;
    logic       bsy;
    logic       drop;
  } vec_t;

  vec_t tbl[15];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < maxc) begin
      tick();
      n++;
    end
    chk(nm, 32'(busy), 32'd0);
  endtask

  task automatic chk_stream(input string nm, input logic [7:0] exp[$]);
    chk({nm, "_len"}, 32'(tx_q.size()), 32'(exp.size()));
    for (int i = 0; i < tx_q.size() && i < exp.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), 32'(tx_q[i]), 32'(exp[i]));
    for (int i = 1; i < cyc_q.size(); i++)
      chk($sformatf("%s_gap%0d", nm, i), 32'(cyc_q[i] - cyc_q[i-1]), 32'd12);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int sent;
    int n;
    logic acc;

    // Single 0xA5 write into an idle FIFO, one row per clock edge.
    tbl[0] = '{rst:1, v:0, d:8'h00, rdy:1, tx:0, txd:8'h00, cnt:0, bsy:0, drop:0};
    tbl[1] = '{rst:0, v:1, d:8'hA5, rdy:1, tx:0, txd:8'h00, cnt:1, bsy:1, drop:0};
    tbl[2] = '{rst:0, v:0, d:8'h00, rdy:1, tx:1, txd:8'hA5, cnt:0, bsy:1, drop:0};
    for (int i = 3; i < 14; i++)
      tbl[i] = '{rst:0, v:0, d:8'h00, rdy:1, tx:0, txd:8'hA5, cnt:0, bsy:1, drop:0};
    tbl[14] = '{rst:0, v:0, d:8'h00, rdy:1, tx:0, txd:8'hA5, cnt:0, bsy:0, drop:0};

    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
    tick(); tick();
    rst = 1'b0;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Reset while in WAIT with three bytes queued.
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = 8'h30 + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_q.delete(); cyc_q.delete();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_transmit", 32'(transmit), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (30) tick();
    chk("midrst_no_pulses", 32'(tx_q.size()), 32'd0);

    // Table-driven single write.
    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst; wr_valid = tbl[i].v; wr_data = tbl[i].d;
      tick();
      chk($sformatf("tbl%0d_wr_ready", i), 32'(wr_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_transmit", i), 32'(transmit), 32'(tbl[i].tx));
      chk($sformatf("tbl%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].txd));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("tbl%0d_wr_drop", i), 32'(wr_drop), 32'(tbl[i].drop));
    end
    rst = 1'b0; wr_valid = 1'b0;

    // Burst of three consecutive writes.
    tx_q.delete(); cyc_q.delete();
    for (int i = 1; i <= 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    wait_idle(100, "burst_drain_timeout");
    exp_q = '{8'h01, 8'h02, 8'h03};
    chk_stream("burst", exp_q);

    // Fill to 8 stored bytes, overflow with 0xFF, then write across a pop while full.
    tx_q.delete(); cyc_q.delete();
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1; wr_data = 8'h10 + 8'(i);
      tick();
    end
    chk("full_count", 32'(count), 32'd8);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    wr_data = 8'hFF;
    tick();
    chk("ovf_wr_drop", 32'(wr_drop), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    wr_valid = 1'b0;
    tick();
    chk("ovf_drop_clear", 32'(wr_drop), 32'd0);
    tick(); tick();
    wr_valid = 1'b1; wr_data = 8'hEE;
    tick();
    chk("fullpop_transmit", 32'(transmit), 32'd1);
    chk("fullpop_count", 32'(count), 32'd7);
    chk("fullpop_refused", 32'(wr_drop), 32'd1);
    tick();
    chk("fullpop_next_count", 32'(count), 32'd8);
    chk("fullpop_next_drop", 32'(wr_drop), 32'd0);
    wr_valid = 1'b0;
    wait_idle(400, "fill_drain_timeout");
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'hEE};
    chk_stream("fill", exp_q);

    // Stream 20 bytes respecting wr_ready; pointers wrap.
    tx_q.delete(); cyc_q.delete();
    sent = 0; n = 0;
    while (sent < 20 && n < 1000) begin
      wr_valid = wr_ready; wr_data = 8'(sent);
      acc = wr_valid && wr_ready;
      tick();
      if (acc) sent++;
      n++;
    end
    wr_valid = 1'b0;
    chk("wrap_feed_done", 32'(sent), 32'd20);
    wait_idle(600, "wrap_drain_timeout");
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
    chk_stream("wrap", exp_q);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
